// File: rtl/switch_input_handshake.sv
// Operator input stage: stalls the PC on an IN instruction until the confirm key is pressed and
// released, capturing the synchronised switch bank once per key press.
module switch_input_handshake #(
   parameter int unsigned DATA_WIDTH      = 16,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_request,
   input  logic                  confirm_n,
   input  logic [DATA_WIDTH-1:0] switches,
   output logic [DATA_WIDTH-1:0] in_data,
   output logic                  stall,
   output logic                  in_valid,
   output logic                  waiting
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] S_IDLE         = 2'd0;
   localparam logic [1:0] S_WAIT_PRESS   = 2'd1;
   localparam logic [1:0] S_WAIT_RELEASE = 2'd2;
   localparam logic [1:0] S_DONE         = 2'd3;

   logic [SYNC_STAGES-1:0] r_key_sync;
   logic [DATA_WIDTH-1:0]  r_sw_sync [SYNC_STAGES];
   logic                   r_deb;
   logic                   r_deb_d;
   logic [CNT_W-1:0]       r_cnt;
   logic [1:0]             r_state;
   logic [DATA_WIDTH-1:0]  r_in_data;
   logic                   r_in_valid;
   logic                   r_waiting;

   logic                   w_sync_key;
   logic [DATA_WIDTH-1:0]  w_sync_sw;
   logic                   w_press_evt;
   logic                   w_release_evt;
   logic [1:0]             w_state_next;
   logic                   w_capture;
   logic                   w_done_pulse;

   // Key chain resets to released (1) so a reset never looks like a press.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_key_sync <= '1;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            r_sw_sync[i] <= '0;
         end
      end else begin
         r_key_sync   <= {r_key_sync[SYNC_STAGES-2:0], confirm_n};
         r_sw_sync[0] <= switches;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            r_sw_sync[i] <= r_sw_sync[i-1];
         end
      end
   end

   assign w_sync_key = r_key_sync[SYNC_STAGES-1];
   assign w_sync_sw  = r_sw_sync[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_deb   <= 1'b1;
         r_deb_d <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_deb_d <= r_deb;
         if (w_sync_key == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_deb <= w_sync_key;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign w_press_evt   = r_deb_d & ~r_deb;
   assign w_release_evt = ~r_deb_d & r_deb;

   // Dropping in_request aborts from any waiting state and takes priority over key events.
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_done_pulse = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_request) w_state_next = S_WAIT_PRESS;
         end
         S_WAIT_PRESS: begin
            if (!in_request) begin
               w_state_next = S_IDLE;
            end else if (w_press_evt) begin
               w_capture    = 1'b1;
               w_state_next = S_WAIT_RELEASE;
            end
         end
         S_WAIT_RELEASE: begin
            if (!in_request) begin
               w_state_next = S_IDLE;
            end else if (w_release_evt) begin
               w_done_pulse = 1'b1;
               w_state_next = S_DONE;
            end
         end
         default: begin
            if (!in_request) w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_in_data  <= '0;
         r_in_valid <= 1'b0;
         r_waiting  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_in_valid <= w_done_pulse;
         r_waiting  <= (w_state_next == S_WAIT_PRESS);
         if (w_capture) r_in_data <= w_sync_sw;
      end
   end

   assign in_data  = r_in_data;
   assign in_valid = r_in_valid;
   assign waiting  = r_waiting;
   assign stall    = in_request & (r_state != S_DONE);

endmodule

// File: tb/tb_switch_input_handshake.sv
// Directed bench for switch_input_handshake with DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
module tb_switch_input_handshake;

   logic        clock;
   logic        reset;
   logic        in_request;
   logic        confirm_n;
   logic [15:0] switches;
   logic [15:0] in_data;
   logic        stall;
   logic        in_valid;
   logic        waiting;

   int vec_cnt  = 0;
   int err_cnt  = 0;
   int valid_seen = 0;

   switch_input_handshake #(
      .DATA_WIDTH      (16),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .in_request (in_request),
      .confirm_n  (confirm_n),
      .switches   (switches),
      .in_data    (in_data),
      .stall      (stall),
      .in_valid   (in_valid),
      .waiting    (waiting)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) if (in_valid) valid_seen++;

   // Inputs change and outputs are checked on the falling edge.
   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset;
      reset = 1'b1; in_request = 1'b0; confirm_n = 1'b1; switches = 16'h0000;
      cycles(2);
      reset = 1'b0;
      #1;
      vec_cnt++; if (in_data !== 16'h0000) begin err_cnt++; $display("FAIL reset_in_data got %h want 0000", in_data); end
      vec_cnt++; if (in_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_in_valid got %b want 0", in_valid); end
      vec_cnt++; if (waiting !== 1'b0) begin err_cnt++; $display("FAIL reset_waiting got %b want 0", waiting); end
      vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall got %b want 0", stall); end
      cycles(1);
   endtask

   // A raw edge reaches deb after 2 sync + 4 debounce edges; the FSM reacts one edge later.
   task automatic test_capture;
      in_request = 1'b1; switches = 16'hA5C3;
      #1;
      vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL cap_stall_immediate got %b want 1", stall); end
      cycles(1);
      vec_cnt++; if (waiting !== 1'b1) begin err_cnt++; $display("FAIL cap_waiting got %b want 1", waiting); end
      cycles(2);
      confirm_n = 1'b0;
      cycles(6);
      vec_cnt++; if (in_data !== 16'h0000) begin err_cnt++; $display("FAIL cap_early got %h want 0000", in_data); end
      cycles(1);
      vec_cnt++; if (in_data !== 16'hA5C3) begin err_cnt++; $display("FAIL cap_data got %h want a5c3", in_data); end
      vec_cnt++; if (waiting !== 1'b0) begin err_cnt++; $display("FAIL cap_waiting_rel got %b want 0", waiting); end
      cycles(3);
      confirm_n = 1'b1;
      cycles(6);
      vec_cnt++; if (in_valid !== 1'b0 || stall !== 1'b1) begin err_cnt++;
         $display("FAIL rel_early valid=%b stall=%b want 0/1", in_valid, stall); end
      cycles(1);
      vec_cnt++; if (in_valid !== 1'b1) begin err_cnt++; $display("FAIL rel_valid got %b want 1", in_valid); end
      vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL rel_stall got %b want 0", stall); end
      cycles(1);
      vec_cnt++; if (in_valid !== 1'b0) begin err_cnt++; $display("FAIL rel_pulse_width got %b want 0", in_valid); end
      cycles(3);
      // Lingering in_request must not re-arm the FSM.
      vec_cnt++; if (waiting !== 1'b0 || stall !== 1'b0) begin err_cnt++;
         $display("FAIL done_hold waiting=%b stall=%b want 0/0", waiting, stall); end
      vec_cnt++; if (valid_seen !== 1) begin err_cnt++; $display("FAIL cap_valid_count got %0d want 1", valid_seen); end
      in_request = 1'b0;
      cycles(1);
   endtask

   task automatic test_bounce;
      in_request = 1'b1; switches = 16'h1234;
      cycles(1);
      for (int i = 0; i < 3; i++) begin
         confirm_n = 1'b0; cycles(2);
         confirm_n = 1'b1; cycles(2);
      end
      cycles(10);
      vec_cnt++; if (in_data !== 16'hA5C3) begin err_cnt++; $display("FAIL bounce_data got %h want a5c3", in_data); end
      vec_cnt++; if (waiting !== 1'b1) begin err_cnt++; $display("FAIL bounce_waiting got %b want 1", waiting); end
      vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL bounce_stall got %b want 1", stall); end
      vec_cnt++; if (valid_seen !== 1) begin err_cnt++; $display("FAIL bounce_valid got %0d want 1", valid_seen); end
   endtask

   task automatic test_abort;
      in_request = 1'b0;
      #1;
      vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL abort_stall got %b want 0", stall); end
      cycles(1);
      vec_cnt++; if (waiting !== 1'b0) begin err_cnt++; $display("FAIL abort_waiting got %b want 0", waiting); end
      confirm_n = 1'b0;
      cycles(10);
      vec_cnt++; if (in_data !== 16'hA5C3) begin err_cnt++; $display("FAIL abort_data got %h want a5c3", in_data); end
      confirm_n = 1'b1;
      cycles(10);
      vec_cnt++; if (valid_seen !== 1) begin err_cnt++; $display("FAIL abort_valid got %0d want 1", valid_seen); end
   endtask

   task automatic test_held_key;
      confirm_n = 1'b0; switches = 16'h0F0F;
      cycles(10);
      in_request = 1'b1;
      cycles(11);
      vec_cnt++; if (in_data !== 16'hA5C3 || waiting !== 1'b1) begin err_cnt++;
         $display("FAIL held_no_capture data=%h waiting=%b want a5c3/1", in_data, waiting); end
      confirm_n = 1'b1;
      cycles(10);
      vec_cnt++; if (in_data !== 16'hA5C3 || waiting !== 1'b1) begin err_cnt++;
         $display("FAIL held_release data=%h waiting=%b want a5c3/1", in_data, waiting); end
      switches = 16'h5A5A;
      cycles(3);
      confirm_n = 1'b0;
      cycles(7);
      switches = 16'hFFFF;
      vec_cnt++; if (in_data !== 16'h5A5A) begin err_cnt++; $display("FAIL held_fresh_press got %h want 5a5a", in_data); end
      cycles(3);
      vec_cnt++; if (in_data !== 16'h5A5A) begin err_cnt++; $display("FAIL held_data_stable got %h want 5a5a", in_data); end
   endtask

   task automatic test_reset_mid;
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      vec_cnt++; if (in_data !== 16'h0000) begin err_cnt++; $display("FAIL midrst_data got %h want 0000", in_data); end
      vec_cnt++; if (in_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_valid got %b want 0", in_valid); end
      vec_cnt++; if (waiting !== 1'b0 || stall !== 1'b1) begin err_cnt++;
         $display("FAIL midrst_idle waiting=%b stall=%b want 0/1", waiting, stall); end
      cycles(1);
      vec_cnt++; if (waiting !== 1'b1) begin err_cnt++; $display("FAIL midrst_rearm got %b want 1", waiting); end
      confirm_n = 1'b1; in_request = 1'b0;
      cycles(10);
   endtask

   initial begin
      test_reset();
      test_capture();
      test_bounce();
      test_abort();
      test_held_key();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
